// File: rtl/window_absdiff_pipe_if.sv
// Valid/ready bus of the abs-diff stage: window + threshold/mode in, per-tap results out.
interface window_absdiff_pipe_if #(
  parameter int DATA_W = 8,
  parameter int TAPS   = 9
);
  localparam int CNT_W = $clog2(TAPS + 1);

  logic                   in_valid;
  logic                   in_ready;
  logic [TAPS*DATA_W-1:0] pix_in;
  logic [DATA_W-1:0]      thr_in;
  logic                   mode_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [TAPS*DATA_W-1:0] diff_out;
  logic [TAPS*DATA_W-1:0] pix_out;
  logic [TAPS-1:0]        mask_out;
  logic [CNT_W-1:0]       cnt_out;

  modport master (
    output in_valid, pix_in, thr_in, mode_in, out_ready,
    input  in_ready, out_valid, diff_out, pix_out, mask_out, cnt_out
  );

  modport slave (
    input  in_valid, pix_in, thr_in, mode_in, out_ready,
    output in_ready, out_valid, diff_out, pix_out, mask_out, cnt_out
  );
endinterface

// File: rtl/window_absdiff_pipe.sv
// Two-stage pipe computing |p[i]-p[CENTER]| per tap with clip, threshold mask and popcount.
// Stage A holds signed differences, stage B holds the final results that drive the outputs.
module window_absdiff_pipe #(
  parameter int DATA_W = 8,
  parameter int TAPS   = 9,
  parameter int CENTER = 4
) (
  input logic                  clk,
  input logic                  rst,
  window_absdiff_pipe_if.slave bus
);
  localparam int CNT_W = $clog2(TAPS + 1);

  generate
    if (CENTER < 0 || CENTER >= TAPS) begin : g_center_check
      $error("window_absdiff_pipe: CENTER=%0d outside 0..%0d", CENTER, TAPS - 1);
    end
  endgenerate

  logic                   va;
  logic                   vb;
  logic                   en_a;
  logic                   en_b;
  logic [TAPS*DATA_W-1:0] pix_a;
  logic [DATA_W-1:0]      thr_a;
  logic                   mode_a;
  logic signed [DATA_W:0] d_in [TAPS];
  logic signed [DATA_W:0] d_a  [TAPS];
  logic [DATA_W-1:0]      mag;
  logic [TAPS*DATA_W-1:0] diff_nxt;
  logic [TAPS-1:0]        mask_nxt;
  logic [CNT_W-1:0]       cnt_nxt;
  logic [TAPS*DATA_W-1:0] diff_b;
  logic [TAPS*DATA_W-1:0] pix_b;
  logic [TAPS-1:0]        mask_b;
  logic [CNT_W-1:0]       cnt_b;

  // A stage may advance whenever the stage after it is empty or draining.
  assign en_b         = !vb || bus.out_ready;
  assign en_a         = !va || en_b;
  assign bus.in_ready = en_a;

  always_comb begin
    for (int i = 0; i < TAPS; i++) begin
      d_in[i] = $signed({1'b0, bus.pix_in[i*DATA_W +: DATA_W]})
              - $signed({1'b0, bus.pix_in[CENTER*DATA_W +: DATA_W]});
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      va     <= 1'b0;
      pix_a  <= '0;
      thr_a  <= '0;
      mode_a <= 1'b0;
      for (int i = 0; i < TAPS; i++) d_a[i] <= '0;
    end else if (en_a) begin
      va     <= bus.in_valid;
      pix_a  <= bus.pix_in;
      thr_a  <= bus.thr_in;
      mode_a <= bus.mode_in;
      d_a    <= d_in;
    end
  end

  // The mask always uses the unclipped magnitude; the clip only shapes diff.
  always_comb begin
    mag      = '0;
    diff_nxt = '0;
    mask_nxt = '0;
    cnt_nxt  = '0;
    for (int i = 0; i < TAPS; i++) begin
      mag         = d_a[i][DATA_W] ? DATA_W'(-d_a[i]) : DATA_W'(d_a[i]);
      mask_nxt[i] = (mag <= thr_a);
      diff_nxt[i*DATA_W +: DATA_W] = (mode_a && (mag > thr_a)) ? thr_a : mag;
      cnt_nxt     = cnt_nxt + CNT_W'(mask_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vb     <= 1'b0;
      diff_b <= '0;
      pix_b  <= '0;
      mask_b <= '0;
      cnt_b  <= '0;
    end else if (en_b) begin
      vb     <= va;
      diff_b <= diff_nxt;
      pix_b  <= pix_a;
      mask_b <= mask_nxt;
      cnt_b  <= cnt_nxt;
    end
  end

  assign bus.out_valid = vb;
  assign bus.diff_out  = diff_b;
  assign bus.pix_out   = pix_b;
  assign bus.mask_out  = mask_b;
  assign bus.cnt_out   = cnt_b;
endmodule
